// File: rtl/ahb_master_interface.sv
// ---------------------------------------------------------------------------
// ahb_master_interface
//
// Turns a single burst command (start address, direction, beat count) into
// AHB-Lite word transfers. The first beat is NONSEQ and later beats are SEQ
// at +4, except that a beat whose address lands on a 1 KB boundary is
// re-issued as NONSEQ. Write words are pulled from a FIFO-like source one per
// accepted address phase. Read words are forwarded straight from hrdata.
//
// Optional feature:
//   AHB_MASTER_ERR_EN  when defined, an ERROR response in any data phase
//                      cancels the burst, forces htrans to IDLE in that same
//                      cycle and pulses err and done together. When it is
//                      undefined, hresp is ignored and err is tied low.
//
// Ports:
//   hclk, hresetn                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_len    burst direction, start address, beats-1
//   wr_req, wr_data                 write word pop and data
//   rd_valid, rd_data               read word output
//   done, err                       completion / abort pulses
//   hreadyin, hrdata, hresp         AHB slave response
//   haddr, hwrite, htrans, hburst,
//   hsize, hwdata                   AHB master outputs
// ---------------------------------------------------------------------------
module ahb_master_interface (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  output logic        wr_req,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  input  logic        hreadyin,
  input  logic [31:0] hrdata,
  input  logic [1:0]  hresp,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hburst,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata
);

  localparam logic [2:0] HSIZE_WORD   = 3'b010;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_LAST
  } state_t;

  state_t      state;
  logic [1:0]  htrans_q;
  logic [3:0]  beats_left;
  logic        data_phase;
  logic        data_active;
  logic        err_hit;
  logic [31:0] next_addr;

  // A data phase is in flight once the first address of the burst has been
  // accepted; in LAST only the final data phase remains.
  assign data_active = ((state == S_ADDR) && data_phase) || (state == S_LAST);
  assign next_addr   = haddr + 32'd4;

`ifdef AHB_MASTER_ERR_EN
  assign err_hit = data_active && (hresp == 2'b01) && !hresetn;
`else
  logic unused_hresp;
  assign unused_hresp = ^hresp;
  assign err_hit      = 1'b0;
`endif

  // Handshake and data strobes are derived from the registered state. They
  // are gated by reset so that a reset cycle never pops, reads or completes,
  // and an ERROR abort suppresses any transfer in the cycle it is seen.
  assign cmd_ready = (state == S_IDLE) && !hresetn;
  assign wr_req    = hwrite && (state == S_ADDR) && hreadyin && !err_hit && !hresetn;
  assign rd_valid  = !hwrite && data_active && hreadyin && !err_hit && !hresetn;
  assign rd_data   = hrdata;
  assign done      = !hresetn && (((state == S_LAST) && hreadyin) || err_hit);
  assign err       = err_hit;
  assign htrans    = err_hit ? TRANS_IDLE : htrans_q;
  assign hsize     = HSIZE_WORD;

  // Burst sequencer. Address-phase signals only advance on edges where the
  // slave is ready, so a stall holds haddr/htrans/hwdata exactly. The last
  // address moves the FSM to LAST, which idles the bus while the final data
  // phase drains; a new command cannot start until that phase is done.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state      <= S_IDLE;
      htrans_q   <= TRANS_IDLE;
      haddr      <= 32'd0;
      hwrite     <= 1'b0;
      hwdata     <= 32'd0;
      hburst     <= BURST_SINGLE;
      beats_left <= 4'd0;
      data_phase <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state      <= S_ADDR;
            haddr      <= cmd_addr;
            hwrite     <= cmd_write;
            htrans_q   <= TRANS_NONSEQ;
            hburst     <= (cmd_len == 4'd0) ? BURST_SINGLE : BURST_INCR;
            beats_left <= cmd_len;
            data_phase <= 1'b0;
          end
        end
        S_ADDR: begin
          if (err_hit) begin
            state    <= S_IDLE;
            htrans_q <= TRANS_IDLE;
          end else if (hreadyin) begin
            data_phase <= 1'b1;
            if (hwrite) begin
              hwdata <= wr_data;
            end
            if (beats_left != 4'd0) begin
              beats_left <= beats_left - 4'd1;
              haddr      <= next_addr;
              // Crossing a 1 KB boundary restarts the burst as NONSEQ.
              htrans_q   <= (next_addr[9:0] == 10'd0) ? TRANS_NONSEQ : TRANS_SEQ;
            end else begin
              htrans_q <= TRANS_IDLE;
              state    <= S_LAST;
            end
          end
        end
        S_LAST: begin
          if (err_hit || hreadyin) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          htrans_q <= TRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_interface.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_interface
//
// Directed bench for ahb_master_interface. Each burst is issued by
// applyStimulus, which logs the bus cycle by cycle; the expected addresses,
// transfer types, data and done cycles below are worked out by hand.
// Cycle 0 is the cycle in which the command is accepted.
// ---------------------------------------------------------------------------
module tb_ahb_master_interface;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        hreadyin;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  ahb_master_interface dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .hreadyin  (hreadyin),
    .hrdata    (hrdata),
    .hresp     (hresp),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .htrans    (htrans),
    .hburst    (hburst),
    .hsize     (hsize),
    .hwdata    (hwdata)
  );

  // 10 ns clock; inputs change 1 ns after the rising edge, outputs are
  // sampled on the falling edge.
  always #5 hclk = ~hclk;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  int checks = 0;
  int errors = 0;

  logic [1:0]  logTrans  [0:40];
  logic [31:0] logAddr   [0:40];
  logic [31:0] logHwdata [0:40];
  logic [2:0]  logBurst  [0:40];
  logic [2:0]  logSize   [0:40];
  logic        logReady  [0:40];
  logic        logWrReq  [0:40];
  logic        logRdValid[0:40];
  int          doneCycle;
  int          doneCount;
  int          errCount;
  int          wrReqCount;
  int          rdValidCount;
  logic [31:0] lastRdData;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Issues one command and logs the bus until one cycle past done, two cycles
  // past an injected reset, or a 40-cycle limit. Bits set in stallMask pull
  // hreadyin low in that cycle; write words count up from 0x10000000 and read
  // words count up from rdBase, one per transfer.
  task automatic applyStimulus(input bit write, input logic [31:0] addr,
                               input logic [3:0] len, input logic [31:0] stallMask,
                               input int resetAt, input int errAt,
                               input logic [31:0] rdBase);
    bit stop;
    for (int i = 0; i <= 40; i++) begin
      logTrans[i] = 'x; logAddr[i] = 'x; logHwdata[i] = 'x; logBurst[i] = 'x;
      logSize[i] = 'x; logReady[i] = 1'bx; logWrReq[i] = 1'bx; logRdValid[i] = 1'bx;
    end
    doneCycle = -1; doneCount = 0; errCount = 0;
    wrReqCount = 0; rdValidCount = 0; lastRdData = 'x;
    cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr; cmd_len = len;
    hreadyin = 1'b1; hresp = 2'b00; hresetn = 1'b0;
    wr_data = 32'h1000_0000; hrdata = rdBase;
    @(negedge hclk);
    logReady[0] = cmd_ready;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    stop = 1'b0;
    for (int cyc = 1; cyc <= 40 && !stop; cyc++) begin
      hreadyin = !stallMask[cyc % 32];
      hresetn  = (cyc == resetAt);
      hresp    = (cyc == errAt) ? 2'b01 : 2'b00;
      wr_data  = 32'h1000_0000 + 32'(wrReqCount);
      hrdata   = rdBase + 32'(rdValidCount);
      @(negedge hclk);
      logTrans[cyc] = htrans; logAddr[cyc] = haddr; logHwdata[cyc] = hwdata;
      logBurst[cyc] = hburst; logSize[cyc] = hsize; logReady[cyc] = cmd_ready;
      logWrReq[cyc] = wr_req; logRdValid[cyc] = rd_valid;
      if (wr_req) wrReqCount++;
      if (rd_valid) begin
        rdValidCount++;
        lastRdData = rd_data;
      end
      if (err) errCount++;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (doneCycle >= 0 && cyc == doneCycle + 1) stop = 1'b1;
      if (resetAt >= 0 && cyc == resetAt + 2) stop = 1'b1;
      @(posedge hclk); #1;
    end
    hresetn = 1'b0; hreadyin = 1'b1; hresp = 2'b00;
    @(posedge hclk); #1;
  endtask

  initial begin
    hresetn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_len = '0; wr_data = '0; hreadyin = 1'b1; hrdata = '0; hresp = 2'b00;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b0;
    @(negedge hclk);
    checkOutput("rst_ready",  32'(cmd_ready), 32'd1);
    checkOutput("rst_htrans", 32'(htrans),    32'(IDLE));
    checkOutput("rst_haddr",  haddr,          32'd0);
    checkOutput("rst_hwrite", 32'(hwrite),    32'd0);
    checkOutput("rst_hwdata", hwdata,         32'd0);
    checkOutput("rst_hburst", 32'(hburst),    32'd0);
    checkOutput("rst_strobe", {28'd0, wr_req, rd_valid, done, err}, 32'd0);
    @(posedge hclk); #1;

    // Four-beat write burst at full speed.
    applyStimulus(1'b1, 32'h8000_0000, 4'd3, 32'd0, -1, -1, 32'd0);
    checkOutput("w4_ready0",  32'(logReady[0]), 32'd1);
    checkOutput("w4_ready1",  32'(logReady[1]), 32'd0);
    checkOutput("w4_t1",      32'(logTrans[1]), 32'(NONSEQ));
    checkOutput("w4_a1",      logAddr[1],       32'h8000_0000);
    checkOutput("w4_t2",      32'(logTrans[2]), 32'(SEQ));
    checkOutput("w4_a2",      logAddr[2],       32'h8000_0004);
    checkOutput("w4_t3",      32'(logTrans[3]), 32'(SEQ));
    checkOutput("w4_a3",      logAddr[3],       32'h8000_0008);
    checkOutput("w4_t4",      32'(logTrans[4]), 32'(SEQ));
    checkOutput("w4_a4",      logAddr[4],       32'h8000_000C);
    checkOutput("w4_t5",      32'(logTrans[5]), 32'(IDLE));
    checkOutput("w4_burst",   32'(logBurst[1]), 32'b001);
    checkOutput("w4_size",    32'(logSize[1]),  32'b010);
    checkOutput("w4_hwdata2", logHwdata[2],     32'h1000_0000);
    checkOutput("w4_hwdata5", logHwdata[5],     32'h1000_0003);
    checkOutput("w4_wrreqs",  32'(wrReqCount),  32'd4);
    checkOutput("w4_done",    32'(doneCycle),   32'd5);
    checkOutput("w4_ndone",   32'(doneCount),   32'd1);
    checkOutput("w4_ready6",  32'(logReady[6]), 32'd1);

    // Single-beat read.
    applyStimulus(1'b0, 32'h8400_0010, 4'd0, 32'd0, -1, -1, 32'hA5A5_A5A5);
    checkOutput("r1_burst",   32'(logBurst[1]),   32'b000);
    checkOutput("r1_t1",      32'(logTrans[1]),   32'(NONSEQ));
    checkOutput("r1_a1",      logAddr[1],         32'h8400_0010);
    checkOutput("r1_rdv2",    32'(logRdValid[2]), 32'd1);
    checkOutput("r1_rdcount", 32'(rdValidCount),  32'd1);
    checkOutput("r1_rddata",  lastRdData,         32'hA5A5_A5A5);
    checkOutput("r1_done",    32'(doneCycle),     32'd2);

    // Two-beat write, slave stalls cycles 2..4 during the second address.
    applyStimulus(1'b1, 32'h9000_0100, 4'd1, 32'h0000_001C, -1, -1, 32'd0);
    checkOutput("ws_t4",      32'(logTrans[4]), 32'(SEQ));
    checkOutput("ws_a4",      logAddr[4],       32'h9000_0104);
    checkOutput("ws_hwdata4", logHwdata[4],     32'h1000_0000);
    checkOutput("ws_wrreq3",  32'(logWrReq[3]), 32'd0);
    checkOutput("ws_hwdata6", logHwdata[6],     32'h1000_0001);
    checkOutput("ws_wrreqs",  32'(wrReqCount),  32'd2);
    checkOutput("ws_done",    32'(doneCycle),   32'd6);

    // Three-beat read crossing a 1 KB boundary.
    applyStimulus(1'b0, 32'h8800_03F8, 4'd2, 32'd0, -1, -1, 32'h0BAD_0000);
    checkOutput("kb_t2",      32'(logTrans[2]), 32'(SEQ));
    checkOutput("kb_a2",      logAddr[2],       32'h8800_03FC);
    checkOutput("kb_t3",      32'(logTrans[3]), 32'(NONSEQ));
    checkOutput("kb_a3",      logAddr[3],       32'h8800_0400);
    checkOutput("kb_rdcount", 32'(rdValidCount), 32'd3);
    checkOutput("kb_rddata",  lastRdData,        32'h0BAD_0002);
    checkOutput("kb_done",    32'(doneCycle),    32'd4);

    // Reset during the second beat of an eight-beat write.
    applyStimulus(1'b1, 32'hA000_0000, 4'd7, 32'd0, 2, -1, 32'd0);
    checkOutput("rs_wrreq2",  32'(logWrReq[2]), 32'd0);
    checkOutput("rs_ready2",  32'(logReady[2]), 32'd0);
    checkOutput("rs_t3",      32'(logTrans[3]), 32'(IDLE));
    checkOutput("rs_a3",      logAddr[3],       32'd0);
    checkOutput("rs_hwdata3", logHwdata[3],     32'd0);
    checkOutput("rs_ready3",  32'(logReady[3]), 32'd1);
    checkOutput("rs_ndone",   32'(doneCount),   32'd0);
    checkOutput("rs_nerr",    32'(errCount),    32'd0);

    // ERROR response in the first beat's data phase of a four-beat read.
    applyStimulus(1'b0, 32'hB000_0000, 4'd3, 32'd0, -1, 2, 32'h5000_0000);
`ifdef AHB_MASTER_ERR_EN
    checkOutput("er_t2",      32'(logTrans[2]),  32'(IDLE));
    checkOutput("er_nerr",    32'(errCount),     32'd1);
    checkOutput("er_done",    32'(doneCycle),    32'd2);
    checkOutput("er_ndone",   32'(doneCount),    32'd1);
    checkOutput("er_t3",      32'(logTrans[3]),  32'(IDLE));
    checkOutput("er_ready3",  32'(logReady[3]),  32'd1);
    checkOutput("er_rdcount", 32'(rdValidCount), 32'd0);
`else
    checkOutput("er_t2",      32'(logTrans[2]),  32'(SEQ));
    checkOutput("er_nerr",    32'(errCount),     32'd0);
    checkOutput("er_done",    32'(doneCycle),    32'd5);
    checkOutput("er_rdcount", 32'(rdValidCount), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
